branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the fetch stage; next generation of the combinational branch-resolution logic.
- Predicts taken/not-taken and target per fetch PC from a table of 2-bit saturating counters plus a tagged BTB.
- Trains from resolved branches reported by execute.
- Supports bimodal mode (GHR_BITS=0) or gshare mode (GHR_BITS>0, history XORed into the index).

---
 rtl/branch_predictor.sv | 141 ++++++++++++++
 tb/tb_branch_predictor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit saturating counters plus a tagged, direct-mapped BTB.
// Bimodal indexing when GHR_BITS=0, gshare (PC index XOR global history) otherwise.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int GHR_BITS = 0
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       pred_valid_i,
  input  logic [XLEN-1:0]                            pred_pc_i,
  output logic                                       pred_valid_o,
  output logic                                       pred_taken_o,
  output logic [XLEN-1:0]                            pred_target_o,
  output logic                                       pred_hit_o,
  output logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] pred_ghr_o,
  input  logic                                       upd_valid_i,
  input  logic [XLEN-1:0]                            upd_pc_i,
  input  logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] upd_ghr_i,
  input  logic                                       upd_taken_i,
  input  logic [XLEN-1:0]                            upd_target_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int GW    = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam int FW    = (GW > IDX_W) ? GW : IDX_W;
  localparam int TLO   = IDX_W + 2;

  logic [1:0]          r_ctr [ENTRIES];
  logic [ENTRIES-1:0]  r_vld;
  logic [TAG_BITS-1:0] r_tag [ENTRIES];
  logic [XLEN-1:0]     r_tgt [ENTRIES];

  logic                r_pvld;
  logic                r_ptaken;
  logic [XLEN-1:0]     r_ptarget;
  logic                r_phit;
  logic [GW-1:0]       r_pghr;

  logic [GW-1:0]       w_ghr;
  logic [GW-1:0]       w_upd_ghr;
  logic [IDX_W-1:0]    w_pidx;
  logic [IDX_W-1:0]    w_uidx;
  logic [TAG_BITS-1:0] w_ptag;
  logic [TAG_BITS-1:0] w_utag;
  logic                w_hit;
  logic                w_taken;
  logic [XLEN-1:0]     w_pc_inc;
  logic [XLEN-1:0]     w_target;
  logic                w_unused;

  // History is zero-extended or truncated to the index width before the XOR.
  function automatic logic [IDX_W-1:0] fold(input logic [GW-1:0] g);
    return IDX_W'(FW'(g));
  endfunction

  generate
    if (GHR_BITS > 1) begin : g_ghr_shift
      logic [GW-1:0] r_ghr;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          r_ghr <= '0;
        else if (upd_valid_i) r_ghr <= {r_ghr[GW-2:0], upd_taken_i};
      end
      assign w_ghr     = r_ghr;
      assign w_upd_ghr = upd_ghr_i;
    end else if (GHR_BITS == 1) begin : g_ghr_one
      logic [GW-1:0] r_ghr;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          r_ghr <= '0;
        else if (upd_valid_i) r_ghr <= upd_taken_i;
      end
      assign w_ghr     = r_ghr;
      assign w_upd_ghr = upd_ghr_i;
    end else begin : g_ghr_none
      assign w_ghr     = '0;
      assign w_upd_ghr = '0;
    end
  endgenerate

  assign w_pidx   = pred_pc_i[IDX_W+1:2] ^ fold(w_ghr);
  assign w_uidx   = upd_pc_i[IDX_W+1:2] ^ fold(w_upd_ghr);
  assign w_ptag   = pred_pc_i[TLO+TAG_BITS-1:TLO];
  assign w_utag   = upd_pc_i[TLO+TAG_BITS-1:TLO];

  assign w_hit    = r_vld[w_pidx] && (r_tag[w_pidx] == w_ptag);
  assign w_taken  = w_hit && r_ctr[w_pidx][1];
  assign w_pc_inc = pred_pc_i + XLEN'(4);
  assign w_target = w_taken ? r_tgt[w_pidx] : w_pc_inc;

  // Reads above see the pre-update table, so a same-cycle update is not bypassed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
      r_vld <= '0;
    end else if (upd_valid_i) begin
      if (upd_taken_i) begin
        if (r_ctr[w_uidx] != 2'b11) r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'b01;
        r_vld[w_uidx] <= 1'b1;
      end else if (r_ctr[w_uidx] != 2'b00) begin
        r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'b01;
      end
    end
  end

  // Tag/target need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (upd_valid_i && upd_taken_i) begin
      r_tag[w_uidx] <= w_utag;
      r_tgt[w_uidx] <= upd_target_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pvld    <= 1'b0;
      r_ptaken  <= 1'b0;
      r_ptarget <= '0;
      r_phit    <= 1'b0;
      r_pghr    <= '0;
    end else begin
      r_pvld <= pred_valid_i;
      if (pred_valid_i) begin
        r_ptaken  <= w_taken;
        r_ptarget <= w_target;
        r_phit    <= w_hit;
        r_pghr    <= w_ghr;
      end
    end
  end

  assign pred_valid_o  = r_pvld;
  assign pred_taken_o  = r_ptaken;
  assign pred_target_o = r_ptarget;
  assign pred_hit_o    = r_phit;
  assign pred_ghr_o    = r_pghr;

  // PC bits outside the index/tag fields and unused history bits are don't-care.
  assign w_unused = &{1'b0, upd_pc_i, upd_ghr_i};

endmodule

// File: tb/tb_branch_predictor.sv
// Checks a bimodal and a gshare (GHR_BITS=4) predictor against a table-level model,
// with directed scenarios followed by randomized predict/update traffic.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pv;
  logic [31:0] ppc;
  logic        uv;
  logic [31:0] upc;
  logic        ut;
  logic [31:0] utgt;
  logic        ughr_b;
  logic [3:0]  ughr_g;

  logic        b_vld, b_tkn, b_hit;
  logic [31:0] b_tgt;
  logic        b_ghr;
  logic        g_vld, g_tkn, g_hit;
  logic [31:0] g_tgt;
  logic [3:0]  g_ghr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_BITS(8), .GHR_BITS(0)) u_bim (
    .clk_i(clk), .rst_ni(rst_n),
    .pred_valid_i(pv), .pred_pc_i(ppc),
    .pred_valid_o(b_vld), .pred_taken_o(b_tkn), .pred_target_o(b_tgt),
    .pred_hit_o(b_hit), .pred_ghr_o(b_ghr),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_ghr_i(ughr_b),
    .upd_taken_i(ut), .upd_target_i(utgt)
  );

  branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_BITS(8), .GHR_BITS(4)) u_gsh (
    .clk_i(clk), .rst_ni(rst_n),
    .pred_valid_i(pv), .pred_pc_i(ppc),
    .pred_valid_o(g_vld), .pred_taken_o(g_tkn), .pred_target_o(g_tgt),
    .pred_hit_o(g_hit), .pred_ghr_o(g_ghr),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_ghr_i(ughr_g),
    .upd_taken_i(ut), .upd_target_i(utgt)
  );

  // Model state: [0] = bimodal instance, [1] = gshare instance.
  int          m_ctr [2][64];
  bit          m_val [2][64];
  logic [31:0] m_tag [2][64];
  logic [31:0] m_tgt [2][64];
  int          m_ghr [2];

  bit          e_vld [2];
  bit          e_tkn [2];
  bit          e_hit [2];
  logic [31:0] e_tgt [2];
  int          e_ghr [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int midx(input int k, input logic [31:0] pc, input int g);
    int i;
    i = int'((pc >> 2) % 64);
    return (k == 1) ? (i ^ (g % 16)) : i;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) begin
        m_ctr[k][i] = 1;
        m_val[k][i] = 1'b0;
        m_tag[k][i] = '0;
        m_tgt[k][i] = '0;
      end
      m_ghr[k] = 0;
      e_vld[k] = 1'b0; e_tkn[k] = 1'b0; e_hit[k] = 1'b0;
      e_tgt[k] = '0;   e_ghr[k] = 0;
    end
  endtask

  task automatic check_all();
    check("b_vld", b_vld, e_vld[0]);
    check("b_tkn", b_tkn, e_tkn[0]);
    check("b_hit", b_hit, e_hit[0]);
    check("b_tgt", b_tgt, e_tgt[0]);
    check("b_ghr", b_ghr, e_ghr[0]);
    check("g_vld", g_vld, e_vld[1]);
    check("g_tkn", g_tkn, e_tkn[1]);
    check("g_hit", g_hit, e_hit[1]);
    check("g_tgt", g_tgt, e_tgt[1]);
    check("g_ghr", g_ghr, e_ghr[1]);
  endtask

  // One cycle: drive, predict from pre-update model, apply update, clock, compare.
  task automatic step(input bit pv_, input logic [31:0] ppc_, input bit uv_,
                      input logic [31:0] upc_, input bit ut_, input logic [31:0] utgt_,
                      input int ug_);
    int i;
    pv = pv_; ppc = ppc_; uv = uv_; upc = upc_; ut = ut_; utgt = utgt_;
    ughr_g = 4'(ug_);
    ughr_b = 1'($urandom % 2);
    for (int k = 0; k < 2; k++) begin
      e_vld[k] = pv_;
      if (pv_) begin
        i = midx(k, ppc_, m_ghr[k]);
        e_hit[k] = m_val[k][i] && (m_tag[k][i] == (ppc_ >> 8) % 256);
        e_tkn[k] = e_hit[k] && (m_ctr[k][i] >= 2);
        e_tgt[k] = e_tkn[k] ? m_tgt[k][i] : ppc_ + 32'd4;
        e_ghr[k] = m_ghr[k];
      end
    end
    if (uv_) begin
      for (int k = 0; k < 2; k++) begin
        i = midx(k, upc_, (k == 1) ? (ug_ % 16) : 0);
        if (ut_) begin
          if (m_ctr[k][i] < 3) m_ctr[k][i]++;
          m_val[k][i] = 1'b1;
          m_tag[k][i] = (upc_ >> 8) % 256;
          m_tgt[k][i] = utgt_;
        end else if (m_ctr[k][i] > 0) begin
          m_ctr[k][i]--;
        end
      end
      m_ghr[1] = (m_ghr[1] * 2 + int'(ut_)) % 16;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input int g);
    step(1'b0, 32'h0, 1'b1, pc, t, tgt, g);
  endtask

  task automatic pred(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 0);
  endtask

  initial begin
    logic [31:0] rpc, rpc2;
    rst_n = 1'b0;
    pv = 0; ppc = 0; uv = 0; upc = 0; ut = 0; utgt = 0; ughr_b = 0; ughr_g = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_b_tgt", b_tgt, 32'h0);
    rst_n = 1'b1;

    // Untrained prediction falls through to pc+4.
    pred(32'h100);
    check("t1_vld", b_vld, 1'b1);
    check("t1_hit", b_hit, 1'b0);
    check("t1_tkn", b_tkn, 1'b0);
    check("t1_tgt", b_tgt, 32'h104);

    upd(32'h100, 1, 32'h200, 0);
    upd(32'h100, 1, 32'h200, 0);
    pred(32'h100);
    check("t2_hit", b_hit, 1'b1);
    check("t2_tkn", b_tkn, 1'b1);
    check("t2_tgt", b_tgt, 32'h200);
    repeat (3) upd(32'h100, 0, 32'h0, 0);
    pred(32'h100);
    check("t2n_hit", b_hit, 1'b1);
    check("t2n_tkn", b_tkn, 1'b0);
    check("t2n_tgt", b_tgt, 32'h104);

    repeat (5) upd(32'h100, 1, 32'h200, 0);
    upd(32'h100, 0, 32'h0, 0);
    pred(32'h100);
    check("t3_sat_tkn", b_tkn, 1'b1);
    upd(32'h100, 0, 32'h0, 0);
    pred(32'h100);
    check("t3_wnt_tkn", b_tkn, 1'b0);

    upd(32'h100, 1, 32'h200, 0);
    pred(32'h200);
    check("t4_hit", b_hit, 1'b0);
    check("t4_tkn", b_tkn, 1'b0);
    check("t4_tgt", b_tgt, 32'h204);

    upd(32'h100, 0, 32'h0, 0);
    step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 0);
    check("t5_same_tkn", b_tkn, 1'b0);
    check("t5_same_hit", b_hit, 1'b1);
    pred(32'h100);
    check("t5_next_tkn", b_tkn, 1'b1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 0);
    check("hold_vld", b_vld, 1'b0);
    check("hold_tkn", b_tkn, 1'b1);
    check("hold_tgt", b_tgt, 32'h200);

    // Reset lands while a prediction and an update are both in flight.
    pv = 1; ppc = 32'h100; uv = 1; upc = 32'h100; ut = 1; utgt = 32'h500;
    #3 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    pred(32'h100);
    check("rst_mid_hit", b_hit, 1'b0);

    upd(32'h40, 1, 32'h400, 0);
    upd(32'h40, 1, 32'h400, 0);
    upd(32'h40, 0, 32'h0, 0);
    upd(32'h40, 1, 32'h400, 0);
    pred(32'h40);
    check("t6_ghr", g_ghr, 4'b1101);
    check("t6_bim_ghr", b_ghr, 1'b0);
    upd(32'h100, 1, 32'h300, 13);
    // GHR is now 4'b1011; 0x118 maps back to gshare idx 13 with tag 1.
    pred(32'h118);
    check("t6_g_hit", g_hit, 1'b1);
    check("t6_g_tkn", g_tkn, 1'b1);
    check("t6_g_tgt", g_tgt, 32'h300);
    // 0x12C maps to gshare idx 0 (bimodal idx of 0x100), which stays untrained.
    pred(32'h12C);
    check("t6_g_bidx_hit", g_hit, 1'b0);
    check("t6_g_bidx_tgt", g_tgt, 32'h130);
    pred(32'hFFFF_FFFC);
    check("wrap_g_tgt", g_tgt, 32'h0);
    check("wrap_b_tgt", b_tgt, 32'h0);

    for (int n = 0; n < 600; n++) begin
      rpc  = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC)
           : ((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2));
      rpc2 = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC)
           : ((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2));
      step(1'($urandom % 4 != 0), rpc, 1'($urandom % 3 != 0), rpc2,
           1'($urandom % 3 != 0), $urandom & 32'hFFFF_FFFC,
           ($urandom % 2 == 0) ? m_ghr[1] : int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
